// File: rtl/muldiv_sched_pkg.sv
// Shared encodings and helpers for the HI/LO multiply/divide scheduler.
package muldiv_sched_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        OP_MUL  = 2'd0,
        OP_MULU = 2'd1,
        OP_DIV  = 2'd2,
        OP_DIVU = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    function automatic logic [XLEN-1:0] neg_if(
        input logic [XLEN-1:0] v,
        input logic            n
    );
        return n ? -v : v;
    endfunction

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [XLEN-1:0] mag(
        input logic [XLEN-1:0] v,
        input logic            sgn
    );
        return neg_if(v, sgn && v[XLEN-1]);
    endfunction

endpackage

// File: rtl/muldiv_sched_div_iter.sv
// Restoring divide on unsigned magnitudes, one quotient bit per step.
module div_iter
    import muldiv_sched_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            last
);

    logic [XLEN-1:0] q_q;
    logic [XLEN-1:0] r_q;
    logic [XLEN-1:0] d_q;
    logic [4:0]      cnt_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // Remainder stays below the divisor, so one extra bit holds the shift.
    assign shifted = {r_q, q_q[XLEN-1]};
    assign diff    = shifted - {1'b0, d_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q   <= '0;
            r_q   <= '0;
            d_q   <= '0;
            cnt_q <= '0;
        end else if (load) begin
            q_q   <= dividend;
            r_q   <= '0;
            d_q   <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            if (!diff[XLEN]) begin
                r_q <= diff[XLEN-1:0];
                q_q <= {q_q[XLEN-2:0], 1'b1};
            end else begin
                r_q <= shifted[XLEN-1:0];
                q_q <= {q_q[XLEN-2:0], 1'b0};
            end
            cnt_q <= cnt_q + 5'd1;
        end
    end

    assign quotient  = q_q;
    assign remainder = r_q;
    assign last      = (cnt_q == 5'd31);

endmodule

// File: rtl/muldiv_sched.sv
// HI/LO multiply/divide scheduler; define MULDIV_DIVZERO_TRAP_EN to keep
// HI/LO and raise div_zero on a divide by zero instead of writing zeros.
module muldiv_sched
    import muldiv_sched_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            done,
    output logic            div_zero
);

    state_e          state_q;
    state_e          state_d;
    op_e             op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            accept;
    logic            b_zero;
    logic            div_signed;
    logic            ext;
    logic [63:0]     prod;
    logic [XLEN-1:0] q_mag;
    logic [XLEN-1:0] r_mag;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;
    logic            last;

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = !req_ready;
    assign accept     = req_valid && req_ready;
    assign b_zero     = (b_q == '0);
    assign div_signed = (op_q == OP_DIV);

    // One 64x64 product covers both signednesses via the extension bit.
    assign ext  = (op_q == OP_MUL);
    assign prod = {{32{ext & a_q[XLEN-1]}}, a_q}
                * {{32{ext & b_q[XLEN-1]}}, b_q};

    assign quot = neg_if(q_mag, div_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]));
    assign rem  = neg_if(r_mag, div_signed && a_q[XLEN-1]);

    div_iter u_div_iter (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (accept && req_op[1]),
        .step      ((state_q == S_DIV) && !b_zero),
        .dividend  (mag(req_a, req_op == OP_DIV)),
        .divisor   (mag(req_b, req_op == OP_DIV)),
        .quotient  (q_mag),
        .remainder (r_mag),
        .last      (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = req_op[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL: state_d = S_IDLE;
            S_DIV: begin
                if (b_zero) begin
                    state_d = S_IDLE;
                end else if (last) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MULDIV_DIVZERO_TRAP_EN
    logic dz_q;
    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q <= OP_MUL;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
`ifdef MULDIV_DIVZERO_TRAP_EN
            dz_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MULDIV_DIVZERO_TRAP_EN
            dz_q <= 1'b0;
`endif
            if (accept) begin
                op_q <= op_e'(req_op);
                a_q  <= req_a;
                b_q  <= req_b;
            end else if (state_q == S_IDLE) begin
                if (hi_we) hi <= wr_data;
                if (lo_we) lo <= wr_data;
            end
            case (state_q)
                S_MUL: begin
                    {hi, lo} <= prod;
                    done     <= 1'b1;
                end
                S_DIV: begin
                    if (b_zero) begin
                        done <= 1'b1;
`ifdef MULDIV_DIVZERO_TRAP_EN
                        dz_q <= 1'b1;
`else
                        hi   <= '0;
                        lo   <= '0;
`endif
                    end
                end
                S_FIX: begin
                    hi   <= rem;
                    lo   <= quot;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Randomized self-checking bench for muldiv_sched against an arithmetic
// reference model of HI/LO; honours MULDIV_DIVZERO_TRAP_EN.
module tb_muldiv_sched;

    localparam logic [1:0] MUL  = 2'd0;
    localparam logic [1:0] MULU = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DIVU = 2'd3;
`ifdef MULDIV_DIVZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wr_data = '0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_sched dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wr_data   (wr_data),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Architectural result of one operation from plain arithmetic.
    task automatic model(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int lat,
                         output bit dz);
        longint sa;
        longint sb;
        longint sp;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        dz = 1'b0;
        lat = 1;
        if (op == MUL) begin
            sp = sa * sb;
            {m_hi, m_lo} = sp;
        end else if (op == MULU) begin
            up = {32'b0, a} * {32'b0, b};
            {m_hi, m_lo} = up;
        end else if (b == 0) begin
            dz = TRAP;
            if (!TRAP) begin
                m_hi = '0;
                m_lo = '0;
            end
        end else begin
            lat = 33;
            if (op == DIV) begin
                sp = sa / sb;
                m_lo = sp[31:0];
                sp = sa % sb;
                m_hi = sp[31:0];
            end else begin
                m_lo = a / b;
                m_hi = a % b;
            end
        end
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bsy);
        lat = 0;
        bsy = 0;
        for (int k = 1; k <= 60; k++) begin
            if (busy) bsy++;
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat,
                          output int bsy);
        start_op(op, a, b);
        wait_done(lat, bsy);
    endtask

    task automatic write_hl(input bit wh, input bit wl, input logic [31:0] d);
        @(negedge clk);
        hi_we = wh;
        lo_we = wl;
        wr_data = d;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (wh) m_hi = d;
        if (wl) m_lo = d;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if ({hi, lo, busy, done, div_zero} !== '0) begin
            failures++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dz=%b required all 0",
                     hi, lo, busy, done, div_zero);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got ready=%b busy=%b required 1/0", req_ready, busy);
        end
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic test_mul();
        int lat;
        int bsy;
        bit dz;
        model(MUL, 32'hFFFFFFFF, 32'd2, lat, dz);
        run_op(MUL, 32'hFFFFFFFF, 32'd2, lat, bsy);
        checks++;
        if (lat !== 1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE) begin
            failures++;
            $display("FAIL mul_signed: got lat=%0d hi=%h lo=%h required 1 ffffffff fffffffe",
                     lat, hi, lo);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || lo !== 32'hFFFFFFFE) begin
            failures++;
            $display("FAIL done_pulse: got done=%b lo=%h required 0 fffffffe", done, lo);
        end
        model(MULU, 32'hFFFFFFFF, 32'd2, lat, dz);
        run_op(MULU, 32'hFFFFFFFF, 32'd2, lat, bsy);
        checks++;
        if (lat !== 1 || hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin
            failures++;
            $display("FAIL mul_unsigned: got lat=%0d hi=%h lo=%h required 1 00000001 fffffffe",
                     lat, hi, lo);
        end
    endtask

    task automatic test_div();
        int lat;
        int bsy;
        bit dz;
        model(DIV, -32'sd7, 32'd2, lat, dz);
        run_op(DIV, -32'sd7, 32'd2, lat, bsy);
        checks++;
        if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL div_neg7: got hi=%h lo=%h required ffffffff fffffffd", hi, lo);
        end
        checks++;
        if (lat !== 33 || bsy !== 33) begin
            failures++;
            $display("FAIL div_timing: got lat=%0d busy_cycles=%0d required 33/33", lat, bsy);
        end
        model(DIV, 32'h80000000, 32'hFFFFFFFF, lat, dz);
        run_op(DIV, 32'h80000000, 32'hFFFFFFFF, lat, bsy);
        checks++;
        if (lo !== 32'h80000000 || hi !== 32'h0 || lat !== 33) begin
            failures++;
            $display("FAIL div_overflow: got hi=%h lo=%h lat=%0d required 0 80000000 33",
                     hi, lo, lat);
        end
    endtask

    task automatic test_divzero();
        int lat;
        int bsy;
        bit dz;
        write_hl(1'b1, 1'b1, 32'hA5A5_5A5A);
        model(DIVU, 32'd7, 32'd0, lat, dz);
        run_op(DIVU, 32'd7, 32'd0, lat, bsy);
        checks++;
        if (lat !== 1 || hi !== m_hi || lo !== m_lo || div_zero !== dz) begin
            failures++;
            $display("FAIL divzero: got lat=%0d hi=%h lo=%h dz=%b required 1 %h %h %b",
                     lat, hi, lo, div_zero, m_hi, m_lo, dz);
        end
        @(posedge clk);
        #1;
        checks++;
        if (div_zero !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL divzero_pulse: got dz=%b done=%b required 0 0", div_zero, done);
        end
    endtask

    task automatic test_write();
        int lat;
        int bsy;
        bit dz;
        logic [31:0] old_lo;
        logic [31:0] old_hi;
        write_hl(1'b0, 1'b1, 32'h1234);
        checks++;
        if (lo !== 32'h1234 || hi !== m_hi) begin
            failures++;
            $display("FAIL idle_lo_we: got hi=%h lo=%h required %h 00001234", hi, lo, m_hi);
        end
        write_hl(1'b1, 1'b1, 32'hCAFE_F00D);
        checks++;
        if (hi !== 32'hCAFEF00D || lo !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL idle_both_we: got hi=%h lo=%h required cafef00d x2", hi, lo);
        end
        old_lo = m_lo;
        model(DIV, 32'd100, 32'd7, lat, dz);
        start_op(DIV, 32'd100, 32'd7);
        @(negedge clk);
        lo_we = 1'b1;
        wr_data = 32'h1234;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        checks++;
        if (lo !== old_lo) begin
            failures++;
            $display("FAIL busy_lo_we: got lo=%h required %h", lo, old_lo);
        end
        wait_done(lat, bsy);
        checks++;
        if (lat == 0 || lo !== 32'd14 || hi !== 32'd2) begin
            failures++;
            $display("FAIL busy_div_result: got lat=%0d hi=%h lo=%h required 2 0000000e",
                     lat, hi, lo);
        end
        old_hi = hi;
        old_lo = lo;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = MUL;
        req_a = 32'd3;
        req_b = 32'd5;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        checks++;
        if (hi !== old_hi || lo !== old_lo) begin
            failures++;
            $display("FAIL accept_vs_we: got hi=%h lo=%h required %h %h", hi, lo, old_hi, old_lo);
        end
        model(MUL, 32'd3, 32'd5, lat, dz);
        wait_done(lat, bsy);
        checks++;
        if (lat !== 1 || hi !== 32'd0 || lo !== 32'd15) begin
            failures++;
            $display("FAIL accept_mul: got lat=%0d hi=%h lo=%h required 1 0 0000000f",
                     lat, hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        write_hl(1'b1, 1'b1, 32'h7777_1111);
        start_op(DIV, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got hi=%h lo=%h busy=%b required 0 0 0", hi, lo, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_ready: got %b required 1", req_ready);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0 || hi !== 32'h0 || lo !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_quiet: got done/busy cycles=%0d hi=%h lo=%h required 0 0 0",
                     seen, hi, lo);
        end
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic test_back_to_back();
        int lat;
        int bsy;
        bit dz;
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom;
        b = $urandom_range(1, 5000);
        model(DIV, a, b, lat, dz);
        run_op(DIV, a, b, lat, bsy);
        checks++;
        if (lat !== 33 || hi !== m_hi || lo !== m_lo || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_div: got lat=%0d hi=%h lo=%h ready=%b required 33 %h %h 1",
                     lat, hi, lo, req_ready, m_hi, m_lo);
        end
        a = $urandom;
        b = $urandom;
        model(MUL, a, b, lat, dz);
        run_op(MUL, a, b, lat, bsy);
        checks++;
        if (lat !== 1 || hi !== m_hi || lo !== m_lo) begin
            failures++;
            $display("FAIL b2b_mul: got lat=%0d hi=%h lo=%h required 1 %h %h",
                     lat, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_random();
        int lat;
        int bsy;
        int exp_lat;
        bit dz;
        logic [1:0] op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 9);
                2: b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            model(op, a, b, exp_lat, dz);
            run_op(op, a, b, lat, bsy);
            checks++;
            if (lat !== exp_lat || hi !== m_hi || lo !== m_lo || div_zero !== dz) begin
                failures++;
                $display("FAIL rand_%0d op=%0d a=%h b=%h: got lat=%0d hi=%h lo=%h dz=%b required %0d %h %h %b",
                         i, op, a, b, lat, hi, lo, div_zero, exp_lat, m_hi, m_lo, dz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_divzero();
        test_write();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
